// File: rtl/kf_pic_scalable.sv
// Parametrised 8259-style interrupt controller: edge/level requests, mask, nested ISR, rotation, auto-EOI.
// Latency: acknowledge -> registered vector one cycle later; register reads return one cycle after the strobe.
// Backpressure: none; every acknowledge is answered on the next cycle, even when another is still being answered.
module kf_pic_scalable #(
  parameter int                      NUM_IRQ      = 8,
  parameter int                      VECTOR_WIDTH = 8,
  parameter logic [VECTOR_WIDTH-1:0] VECTOR_BASE  = 8'h20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [1:0]              address,
  input  logic [NUM_IRQ-1:0]      data_in,
  output logic [NUM_IRQ-1:0]      data_out,
  input  logic [NUM_IRQ-1:0]      interrupt_request,
  output logic                    interrupt_to_cpu,
  input  logic                    interrupt_acknowledge,
  output logic                    ack_valid,
  output logic [VECTOR_WIDTH-1:0] vector,
  output logic                    ack_spurious
);

  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam int PAD   = 1 << IDX_W;

  logic [NUM_IRQ-1:0]      mask_q, mask_d;
  logic [NUM_IRQ-1:0]      trig_q, trig_d;
  logic [NUM_IRQ-1:0]      irr_q, irr_d;
  logic [NUM_IRQ-1:0]      isr_q, isr_d;
  logic [NUM_IRQ-1:0]      prev_q;
  logic [NUM_IRQ-1:0]      dout_q, dout_d;
  logic                    rot_q, rot_d;
  logic                    aeoi_q, aeoi_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic                    int_q, int_d;
  logic                    av_q, av_d;
  logic                    spur_q, spur_d;
  logic [VECTOR_WIDTH-1:0] vec_q, vec_d;

  // Priority walk results: first eligible request and first in-service level.
  logic [NUM_IRQ-1:0] pending;
  logic               cand_vld;
  logic [IDX_W-1:0]   cand_idx;
  logic               isr_vld;
  logic [IDX_W-1:0]   isr_idx;
  int                 pos;
  logic [IDX_W-1:0]   pos_idx;

  // EOI decode and per-cycle one-hot update vectors.
  logic [IDX_W-1:0]   spec_idx;
  logic [PAD-1:0]     isr_pad;
  logic               eoi_hit;
  logic [IDX_W-1:0]   eoi_lvl;
  logic [NUM_IRQ-1:0] eoi_clr;
  logic [NUM_IRQ-1:0] ack_hot;
  logic               ack_take;

  assign pending = irr_q & ~mask_q;

  // Walk from pointer+1 around the ring; an in-service level stops any request at or below it.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    isr_vld  = 1'b0;
    isr_idx  = '0;
    pos      = 0;
    pos_idx  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      pos = int'(ptr_q) + 1 + k;
      if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
      pos_idx = IDX_W'(pos);
      if (!isr_vld) begin
        if (isr_q[pos_idx]) begin
          isr_vld = 1'b1;
          isr_idx = pos_idx;
        end else if (!cand_vld && pending[pos_idx]) begin
          cand_vld = 1'b1;
          cand_idx = pos_idx;
        end
      end
    end
  end

  // Next-state: register port, EOI (applied before acknowledge), acknowledge, request capture.
  always_comb begin
    mask_d   = mask_q;
    trig_d   = trig_q;
    isr_d    = isr_q;
    dout_d   = dout_q;
    rot_d    = rot_q;
    aeoi_d   = aeoi_q;
    ptr_d    = ptr_q;
    vec_d    = vec_q;
    av_d     = 1'b0;
    spur_d   = 1'b0;
    spec_idx = data_in[IDX_W-1:0];
    isr_pad  = PAD'(isr_q);
    eoi_hit  = 1'b0;
    eoi_lvl  = '0;
    eoi_clr  = '0;
    ack_take = interrupt_acknowledge && cand_vld;
    ack_hot  = ack_take ? (NUM_IRQ'(1) << cand_idx) : '0;

    // Reads always see the pre-write register contents.
    if (read_enable) begin
      case (address)
        2'd0:    dout_d = mask_q;
        2'd1:    dout_d = trig_q;
        2'd2:    dout_d = irr_q;
        default: dout_d = isr_q;
      endcase
    end

    if (write_enable) begin
      case (address)
        2'd0: mask_d = data_in;
        2'd1: trig_d = data_in;
        2'd2: begin
          if (data_in[NUM_IRQ-1]) begin
            eoi_hit = isr_pad[spec_idx];
            eoi_lvl = spec_idx;
          end else begin
            eoi_hit = isr_vld;
            eoi_lvl = isr_idx;
          end
        end
        default: begin
          rot_d  = data_in[0];
          aeoi_d = data_in[1];
        end
      endcase
    end

    if (eoi_hit) begin
      eoi_clr = NUM_IRQ'(1) << eoi_lvl;
      if (rot_q) ptr_d = eoi_lvl;
    end
    isr_d = isr_q & ~eoi_clr;

    if (interrupt_acknowledge) begin
      av_d = 1'b1;
      if (cand_vld) begin
        vec_d = VECTOR_BASE + VECTOR_WIDTH'(cand_idx);
        if (!aeoi_q) isr_d = isr_d | ack_hot;
        else if (rot_q) ptr_d = cand_idx;
      end else begin
        vec_d  = VECTOR_BASE + VECTOR_WIDTH'(NUM_IRQ - 1);
        spur_d = 1'b1;
      end
    end

    // Level bits track the pin, acknowledge clears, and a fresh edge always wins.
    irr_d = (irr_q & ~trig_q) | (interrupt_request & trig_q);
    irr_d = irr_d & ~ack_hot;
    irr_d = irr_d | (interrupt_request & ~prev_q & ~trig_q);

    int_d = cand_vld && !interrupt_acknowledge;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '1;
      trig_q <= '0;
      irr_q  <= '0;
      isr_q  <= '0;
      prev_q <= '0;
      dout_q <= '0;
      rot_q  <= 1'b0;
      aeoi_q <= 1'b0;
      ptr_q  <= IDX_W'(NUM_IRQ - 1);
      int_q  <= 1'b0;
      av_q   <= 1'b0;
      spur_q <= 1'b0;
      vec_q  <= '0;
    end else begin
      mask_q <= mask_d;
      trig_q <= trig_d;
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      prev_q <= interrupt_request;
      dout_q <= dout_d;
      rot_q  <= rot_d;
      aeoi_q <= aeoi_d;
      ptr_q  <= ptr_d;
      int_q  <= int_d;
      av_q   <= av_d;
      spur_q <= spur_d;
      vec_q  <= vec_d;
    end
  end

  assign data_out         = dout_q;
  assign interrupt_to_cpu = int_q;
  assign ack_valid        = av_q;
  assign vector           = vec_q;
  assign ack_spurious     = spur_q;

endmodule

// File: tb/tb_kf_pic_scalable.sv
// Bench for kf_pic_scalable: directed scenarios against fixed values, then random traffic against a reference model.
// Latency: inputs are applied between edges and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the controller never stalls, so every tick is checked.
module tb_kf_pic_scalable;

  localparam int        N    = 8;
  localparam bit [7:0]  BASE = 8'h20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0, re = 1'b0, ack = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00, irq = 8'h00;
  logic [7:0] dout, vec;
  logic       int_o, av, spur;

  int n_vec = 0;
  int n_err = 0;

  kf_pic_scalable #(.NUM_IRQ(N), .VECTOR_WIDTH(8), .VECTOR_BASE(BASE)) dut (
    .clock(clock), .reset(reset), .write_enable(we), .read_enable(re),
    .address(addr), .data_in(din), .data_out(dout),
    .interrupt_request(irq), .interrupt_to_cpu(int_o),
    .interrupt_acknowledge(ack), .ack_valid(av), .vector(vec), .ack_spurious(spur)
  );

  always #5 clock = ~clock;

  // Reference model: architectural state only, priority via rank arithmetic.
  bit [7:0] m_mask, m_trig, m_irr, m_isr, m_prev, m_dout, m_vec;
  int       m_ptr;
  bit       m_rot, m_aeoi, m_int, m_av, m_spur;

  function automatic int rank(input int i);
    return (i - m_ptr - 1 + 2 * N) % N;
  endfunction

  function automatic int best(input bit [7:0] v);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (b < 0 || rank(i) < rank(b))) b = i;
    return b;
  endfunction

  function automatic int m_cand();
    int c = best(m_irr & ~m_mask);
    int t = best(m_isr);
    if (c >= 0 && (t < 0 || rank(c) < rank(t))) return c;
    return -1;
  endfunction

  task automatic model_step();
    int       c, lvl;
    bit [7:0] o_irr, o_trig;
    bit       o_rot, o_aeoi;
    if (reset) begin
      m_mask = 8'hFF; m_trig = 0; m_irr = 0; m_isr = 0; m_prev = 0; m_dout = 0;
      m_vec = 0; m_ptr = N - 1; m_rot = 0; m_aeoi = 0; m_int = 0; m_av = 0; m_spur = 0;
      return;
    end
    c = m_cand();
    o_irr = m_irr; o_trig = m_trig; o_rot = m_rot; o_aeoi = m_aeoi;
    if (re) m_dout = (addr == 0) ? m_mask : (addr == 1) ? m_trig : (addr == 2) ? m_irr : m_isr;
    if (we) begin
      if (addr == 0) m_mask = din;
      else if (addr == 1) m_trig = din;
      else if (addr == 3) begin m_rot = din[0]; m_aeoi = din[1]; end
      else begin
        lvl = -1;
        if (din[N-1]) begin
          if (m_isr[din[2:0]]) lvl = int'(din[2:0]);
        end else lvl = best(m_isr);
        if (lvl >= 0) begin
          m_isr[lvl] = 1'b0;
          if (o_rot) m_ptr = lvl;
        end
      end
    end
    m_av = ack; m_spur = 0;
    if (ack) begin
      if (c >= 0) begin
        m_vec = BASE + 8'(c);
        o_irr[c] = 1'b0;
        if (!o_aeoi) m_isr[c] = 1'b1;
        else if (o_rot) m_ptr = c;
      end else begin
        m_vec = BASE + 8'(N - 1);
        m_spur = 1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (o_trig[i]) m_irr[i] = irq[i] && !(ack && c == i);
      else m_irr[i] = o_irr[i] || (irq[i] && !m_prev[i]);
    end
    m_int = (c >= 0) && !ack;
    m_prev = irq;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1; addr = a; din = d; tick(); we = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    re = 1; addr = a; tick(); re = 0;
  endtask

  task automatic pulse(input logic [7:0] b);
    irq = b; tick(); irq = 0;
  endtask

  task automatic do_ack();
    ack = 1; tick(); ack = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL reset_int got %b want 0", int_o); end
    n_vec++; if (av !== 1'b0 || spur !== 1'b0 || vec !== 8'h00) begin n_err++; $display("FAIL reset_ack got av=%b sp=%b v=%h want 0/0/00", av, spur, vec); end
    rd(2'd0);
    n_vec++; if (dout !== 8'hFF) begin n_err++; $display("FAIL reset_mask got %h want ff", dout); end
    rd(2'd1);
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_trig got %h want 00", dout); end
  endtask

  task automatic test_edge_ack();
    do_reset(); wr(2'd0, 8'h00);
    pulse(8'h08);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL edge_int_early got %b want 0", int_o); end
    rd(2'd2);
    n_vec++; if (dout !== 8'h08) begin n_err++; $display("FAIL edge_irr got %h want 08", dout); end
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL edge_int got %b want 1", int_o); end
    do_ack();
    n_vec++; if (av !== 1'b1 || vec !== 8'h23 || spur !== 1'b0) begin n_err++; $display("FAIL edge_ack got av=%b v=%h sp=%b want 1/23/0", av, vec, spur); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL edge_int_ack got %b want 0", int_o); end
    rd(2'd3);
    n_vec++; if (dout !== 8'h08 || av !== 1'b0) begin n_err++; $display("FAIL edge_isr got %h av=%b want 08 av=0", dout, av); end
    rd(2'd2);
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL edge_irr_clr got %h want 00", dout); end
  endtask

  task automatic test_nested();
    do_reset(); wr(2'd0, 8'h00);
    pulse(8'h24);
    do_ack();
    n_vec++; if (vec !== 8'h22 || spur !== 1'b0) begin n_err++; $display("FAIL nest_first got v=%h sp=%b want 22/0", vec, spur); end
    do_ack();
    n_vec++; if (av !== 1'b1 || vec !== 8'h27 || spur !== 1'b1) begin n_err++; $display("FAIL nest_blocked got av=%b v=%h sp=%b want 1/27/1", av, vec, spur); end
    wr(2'd2, 8'h00);
    do_ack();
    n_vec++; if (vec !== 8'h25 || spur !== 1'b0) begin n_err++; $display("FAIL nest_after_eoi got v=%h sp=%b want 25/0", vec, spur); end
  endtask

  task automatic test_rotate();
    do_reset(); wr(2'd0, 8'h00); wr(2'd3, 8'h01);
    pulse(8'h03);
    do_ack();
    n_vec++; if (vec !== 8'h20) begin n_err++; $display("FAIL rot_first got %h want 20", vec); end
    wr(2'd2, 8'h00);
    pulse(8'h01);
    do_ack();
    n_vec++; if (vec !== 8'h21) begin n_err++; $display("FAIL rot_second got %h want 21", vec); end
    wr(2'd2, 8'h00);
    do_ack();
    n_vec++; if (vec !== 8'h20 || spur !== 1'b0) begin n_err++; $display("FAIL rot_third got v=%h sp=%b want 20/0", vec, spur); end
  endtask

  task automatic test_level();
    do_reset(); wr(2'd0, 8'h00); wr(2'd1, 8'h40);
    irq = 8'h40; tick(); tick();
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL lvl_int_on got %b want 1", int_o); end
    irq = 8'h00; tick(); tick();
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL lvl_int_off got %b want 0", int_o); end
    rd(2'd2);
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL lvl_irr_drop got %h want 00", dout); end
    irq = 8'h40; tick();
    do_ack();
    irq = 8'h00;
    n_vec++; if (vec !== 8'h26 || spur !== 1'b0) begin n_err++; $display("FAIL lvl_ack got v=%h sp=%b want 26/0", vec, spur); end
  endtask

  task automatic test_auto_eoi();
    do_reset(); wr(2'd0, 8'h00); wr(2'd3, 8'h02);
    pulse(8'h90);
    do_ack();
    n_vec++; if (vec !== 8'h24 || spur !== 1'b0) begin n_err++; $display("FAIL aeoi_first got v=%h sp=%b want 24/0", vec, spur); end
    do_ack();
    n_vec++; if (av !== 1'b1 || vec !== 8'h27 || spur !== 1'b0) begin n_err++; $display("FAIL aeoi_b2b got av=%b v=%h sp=%b want 1/27/0", av, vec, spur); end
    rd(2'd3);
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL aeoi_isr got %h want 00", dout); end
  endtask

  task automatic test_reset_mid();
    do_reset(); wr(2'd0, 8'h00);
    pulse(8'h02);
    ack = 1; reset = 1; tick(); ack = 0; reset = 0;
    n_vec++; if (av !== 1'b0 || spur !== 1'b0 || vec !== 8'h00 || int_o !== 1'b0 || dout !== 8'h00) begin
      n_err++; $display("FAIL mid_reset got av=%b sp=%b v=%h int=%b d=%h want all 0", av, spur, vec, int_o, dout);
    end
    rd(2'd0);
    n_vec++; if (dout !== 8'hFF) begin n_err++; $display("FAIL mid_reset_mask got %h want ff", dout); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom_range(0, 3));
      din   = 8'($urandom);
      if (we && addr == 2'd0) din = din & 8'($urandom) & 8'($urandom);
      irq   = 8'($urandom & $urandom & $urandom);
      ack   = ($urandom_range(0, 3) == 0);
      tick();
      n_vec++; if (dout !== m_dout) begin n_err++; $display("FAIL rnd_dout c=%0d got %h want %h", cyc, dout, m_dout); end
      n_vec++; if (int_o !== m_int) begin n_err++; $display("FAIL rnd_int c=%0d got %b want %b", cyc, int_o, m_int); end
      n_vec++; if (av !== m_av || spur !== m_spur) begin n_err++; $display("FAIL rnd_ack c=%0d got av=%b sp=%b want %b/%b", cyc, av, spur, m_av, m_spur); end
      if (m_av) begin
        n_vec++; if (vec !== m_vec) begin n_err++; $display("FAIL rnd_vec c=%0d got %h want %h", cyc, vec, m_vec); end
      end
    end
    reset = 0; we = 0; re = 0; ack = 0; irq = 0;
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_nested();
    test_rotate();
    test_level();
    test_auto_eoi();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kf_pic_scalable.md
Name: kf_pic_scalable

Overview:
- Parametrised successor to the 8259-class interrupt controller: NUM_IRQ request channels, each configurable as edge or level.
- Per-channel mask, in-service tracking with fully-nested priority and optional rotating priority, and automatic-EOI mode.
- Single-cycle acknowledge handshake that returns a registered vector.
- Sits between peripheral IRQ lines and the CPU core; programmed over a simple synchronous register port.

Parameters:
NUM_IRQ, 8, number of request channels; legal range 4..32; IDX_W = clog2(NUM_IRQ).
VECTOR_WIDTH, 8, width of the vector output.
VECTOR_BASE, 8'h20, vector for channel 0; channel i returns VECTOR_BASE+i, truncated to VECTOR_WIDTH.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
write_enable  in  1  one-cycle register write strobe.
read_enable  in  1  one-cycle register read strobe.
address  in  2  register select.
data_in  in  NUM_IRQ  write data.
data_out  out  NUM_IRQ  read data, registered.
interrupt_request  in  NUM_IRQ  request pins, already synchronous to clock.
interrupt_to_cpu  out  1  pending-interrupt request to the CPU.
interrupt_acknowledge  in  1  one-cycle acknowledge pulse from the CPU.
ack_valid  out  1  one-cycle pulse; vector and ack_spurious are valid.
vector  out  VECTOR_WIDTH  acknowledged vector.
ack_spurious  out  1  acknowledge arrived with no eligible request.

Behaviour:
- Reset: mask = all ones, trigger = 0 (all edge), IRR = 0, ISR = 0, control = 0, priority pointer = NUM_IRQ-1 (channel 0 highest), previous-pin register = 0. All outputs are 0.
- Registers:
  - address 0: MASK, read/write.
  - address 1: TRIGGER, read/write; 1 = level, 0 = edge.
  - address 2: read returns IRR; write is an EOI command. data_in[NUM_IRQ-1]=1 means specific EOI on level data_in[IDX_W-1:0]; otherwise non-specific EOI clears the highest-priority set ISR bit.
  - address 3: read returns ISR; write sets CONTROL. bit0 = rotate_on_eoi, bit1 = auto_eoi. Read-back is {0..., auto_eoi, rotate_on_eoi} on reads of address 3? No: reads of address 3 return ISR; CONTROL is write-only.
- Reads: data_out is updated the cycle after read_enable and holds its value otherwise.
- Write/read collision: if write_enable and read_enable are both high, the write takes effect and data_out returns the pre-write value.
- Request detection:
  - Edge channel: IRR bit is set when pin=1 and previous sample=0.
  - Level channel: IRR bit follows the pin each cycle, except that it is cleared by acknowledge.
  - Masking never clears IRR.
- Priority:
  - Priority order starts at pointer+1 (highest) and wraps modulo NUM_IRQ.
  - Candidate = highest-priority bit of IRR & ~MASK whose priority is strictly above the highest set ISR bit (any ISR bit blocks equal and lower levels).
- interrupt_to_cpu: registered, equal to candidate_valid from the previous cycle. It is forced to 0 in the cycle in which ack_valid is driven.
- Acknowledge, 1-cycle latency: interrupt_acknowledge at cycle N produces ack_valid=1 at N+1.
  - With a candidate at N: vector = VECTOR_BASE + idx, ack_spurious = 0, IRR[idx] cleared. ISR[idx] is set unless auto_eoi is on.
  - Without a candidate: vector = VECTOR_BASE + NUM_IRQ-1, ack_spurious = 1, no state change.
  - An acknowledge arriving while ack_valid is high is processed normally next cycle; there is no stall.
- EOI: clears the targeted ISR bit.
  - Specific EOI to a clear bit has no effect.
  - Non-specific EOI with ISR = 0 has no effect.
  - If rotate_on_eoi = 1 and a bit was cleared, pointer = that level, so it becomes lowest priority.
  - In auto_eoi mode the rotation is applied at acknowledge time instead.
- Simultaneous events:
  - EOI write and acknowledge in the same cycle: the EOI is applied first, and the candidate is computed on the pre-EOI ISR.
  - A new edge on the channel being acknowledged in the same cycle: the set wins and IRR stays 1.
  - A MASK write takes effect for the candidate in the next cycle.
- Reset mid-operation: all state is cleared and any pending ack_valid is suppressed.

Test Plan:
1. Reset, write MASK = 0x00, pulse interrupt_request[3] (edge) -> IRR = 0x08; interrupt_to_cpu = 1 two cycles after the edge; acknowledge -> ack_valid with vector = 0x23, ISR = 0x08, IRR = 0x00.
2. Channels 5 and 2 pending, ISR = 0 -> first acknowledge returns 0x22. A second acknowledge before EOI returns 0x25 only if ISR permits; with ISR[2] set, channel 5 is blocked and ack_spurious = 1 with vector 0x27. Non-specific EOI, then acknowledge -> 0x25.
3. Set rotate_on_eoi, pending on channels 0 and 1, acknowledge (0x20), EOI; re-raise channel 0 -> next acknowledge returns 0x21 before 0x20.
4. TRIGGER bit 6 = 1 (level), hold pin 6 high, then drop it before acknowledge -> IRR[6] clears and interrupt_to_cpu deasserts. Hold it again and acknowledge -> 0x26.
5. Set auto_eoi, acknowledge channel 4 -> vector 0x24, ISR stays 0x00, and lower-priority channel 7 can be acknowledged immediately afterwards.
6. Assert reset while an acknowledge is in flight -> ack_valid = 0 next cycle, MASK = all ones, and all outputs are 0.
